// File: rtl/vm_dispense_controller.sv
// vm_dispense_controller
// Vending sequencer: accumulates coin credit, accepts an item selection
// against a fixed price table, runs the dispense motor through a
// request/done handshake with a timeout, then pays out change as a greedy
// series of coin-ejector pulses separated by gap cycles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | taking coins, waiting for item_req or cancel
// VEND   | motor held one-hot, waiting for motor_done or timeout
// CHANGE | paying out credit, alternating pulse and gap cycles
//
// Ports
//   clk            system clock (divided domain)
//   reset          asynchronous active-low reset
//   nickel/dime/quarter  single-cycle coin pulses
//   item_req, item_sel   item selection strobe and index
//   cancel         single-cycle refund request
//   motor_done     dispense complete (level, sampled only in VEND)
//   motor          one-hot motor drive
//   eject_*        one-cycle change pulses
//   coin_reject    one-cycle pulse, coin returned mechanically
//   insufficient   one-cycle pulse, item_req with credit < price
//   fault          one-cycle pulse, motor timeout
//   credit         current credit / remaining change in cents
//   busy           high whenever not in IDLE
module vm_dispense_controller #(
  parameter int PRICE0        = 15,
  parameter int PRICE1        = 25,
  parameter int PRICE2        = 35,
  parameter int PRICE3        = 50,
  parameter int MAX_CREDIT    = 95,
  parameter int MOTOR_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       item_req,
  input  logic [1:0] item_sel,
  input  logic       cancel,
  input  logic       motor_done,
  output logic [3:0] motor,
  output logic       eject_quarter,
  output logic       eject_dime,
  output logic       eject_nickel,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       fault,
  output logic [6:0] credit,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam int              CNT_W    = $clog2(MOTOR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOTOR_TIMEOUT - 1);

  function automatic logic [6:0] price_of(input logic [1:0] sel);
    case (sel)
      2'd0:    price_of = 7'(PRICE0);
      2'd1:    price_of = 7'(PRICE1);
      2'd2:    price_of = 7'(PRICE2);
      default: price_of = 7'(PRICE3);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       credit_d, pre_credit_q, pre_credit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gap_q, gap_d;
  logic [3:0]       motor_d;
  logic             ej_q_d, ej_d_d, ej_n_d, rej_d, ins_d, fault_d, busy_d;

  logic             any_coin, multi_coin, coin_fits, afford;
  logic [6:0]       coin_val, price;
  logic [7:0]       coin_sum;

  always_comb begin
    any_coin   = nickel | dime | quarter;
    multi_coin = (nickel & dime) | (nickel & quarter) | (dime & quarter);
    coin_val   = quarter ? 7'd25 : dime ? 7'd10 : nickel ? 7'd5 : 7'd0;
    // Widened add so the limit check can never be fooled by a wrap.
    coin_sum   = {1'b0, credit} + {1'b0, coin_val};
    coin_fits  = coin_sum <= 8'(MAX_CREDIT);
    price      = price_of(item_sel);
    afford     = credit >= price;
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit;
    pre_credit_d = pre_credit_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    motor_d      = motor;
    ej_q_d       = 1'b0;
    ej_d_d       = 1'b0;
    ej_n_d       = 1'b0;
    rej_d        = 1'b0;
    ins_d        = 1'b0;
    fault_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cancel) begin
          rej_d = any_coin;
          if (credit != 7'd0) begin
            state_d = CHANGE;
            gap_d   = 1'b0;
          end
        end else if (item_req && afford) begin
          rej_d        = any_coin;
          motor_d      = 4'b0001 << item_sel;
          pre_credit_d = credit;
          credit_d     = credit - price;
          cnt_d        = '0;
          state_d      = VEND;
        end else begin
          ins_d = item_req;
          if (any_coin) begin
            rej_d = multi_coin | ~coin_fits;
            if (coin_fits) credit_d = coin_sum[6:0];
          end
        end
      end
      VEND: begin
        rej_d = any_coin;
        if (motor_done) begin
          motor_d = 4'b0000;
          gap_d   = 1'b0;
          state_d = CHANGE;
        end else if (cnt_q == CNT_LAST) begin
          // Timeout: refund everything that was in the machine before the vend.
          motor_d  = 4'b0000;
          fault_d  = 1'b1;
          credit_d = pre_credit_q;
          gap_d    = 1'b0;
          state_d  = CHANGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHANGE: begin
        rej_d = any_coin;
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (credit == 7'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = 1'b1;
          if (credit >= 7'd25) begin
            ej_q_d   = 1'b1;
            credit_d = credit - 7'd25;
          end else if (credit >= 7'd10) begin
            ej_d_d   = 1'b1;
            credit_d = credit - 7'd10;
          end else begin
            ej_n_d   = 1'b1;
            credit_d = credit - 7'd5;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      credit        <= 7'd0;
      pre_credit_q  <= 7'd0;
      cnt_q         <= '0;
      gap_q         <= 1'b0;
      motor         <= 4'b0000;
      eject_quarter <= 1'b0;
      eject_dime    <= 1'b0;
      eject_nickel  <= 1'b0;
      coin_reject   <= 1'b0;
      insufficient  <= 1'b0;
      fault         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit        <= credit_d;
      pre_credit_q  <= pre_credit_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      motor         <= motor_d;
      eject_quarter <= ej_q_d;
      eject_dime    <= ej_d_d;
      eject_nickel  <= ej_n_d;
      coin_reject   <= rej_d;
      insufficient  <= ins_d;
      fault         <= fault_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: doc/vm_dispense_controller.md
Name: vm_dispense_controller

Overview:
Sequencing controller for the vending datapath. It accumulates coin credit from single-cycle coin pulses and accepts an item selection against a per-item price table. It then drives the selected dispense motor through a request/done handshake and returns change as a greedy sequence of coin-ejector pulses. It sits between the one-pulse coin/button conditioners and the physical motor and coin-ejector outputs, on the divided system clock.

Parameters:
PRICE0, 15, price of item 0 in cents (multiple of 5)
PRICE1, 25, price of item 1 in cents
PRICE2, 35, price of item 2 in cents
PRICE3, 50, price of item 3 in cents
MAX_CREDIT, 95, maximum accepted credit in cents (must be <128)
MOTOR_TIMEOUT, 8, cycles allowed for motor_done before fault

Ports:
clk  input  1  system clock (divided clock domain)
reset  input  1  asynchronous active-low reset
nickel  input  1  single-cycle 5c coin pulse
dime  input  1  single-cycle 10c coin pulse
quarter  input  1  single-cycle 25c coin pulse
item_req  input  1  single-cycle item selection strobe
item_sel  input  2  item index, valid with item_req
cancel  input  1  single-cycle refund request
motor_done  input  1  dispense complete, level, sampled only in VEND
motor  output  4  one-hot motor drive, held high through VEND
eject_quarter  output  1  one-cycle 25c change pulse
eject_dime  output  1  one-cycle 10c change pulse
eject_nickel  output  1  one-cycle 5c change pulse
coin_reject  output  1  one-cycle pulse: coin not accepted, returned mechanically
insufficient  output  1  one-cycle pulse: item_req with credit < price
fault  output  1  one-cycle pulse: motor timeout
credit  output  7  current credit / remaining change, cents
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset (reset=0, async) forces state IDLE, credit 0, all outputs 0, and clears the timeout counter and gap flag. Reset mid-VEND or mid-CHANGE discards the credit; there is no recovery.
- States: IDLE, VEND, CHANGE.
- IDLE, per cycle, in priority order:
  - cancel: if credit>0, go CHANGE. Otherwise no effect.
  - item_req with credit >= price[item_sel]: motor[item_sel]=1 at the next edge, go VEND, load credit := credit - price.
  - item_req with credit < price: insufficient=1 for 1 cycle, stay IDLE.
- Coins in IDLE:
  - Accepted only if no cancel or successful item_req occurs in the same cycle.
  - If more than one coin pulse is high, accept the highest value (quarter>dime>nickel). Reject the others with coin_reject=1.
  - A coin that would push credit above MAX_CREDIT is rejected with coin_reject=1, and credit is unchanged.
  - Coins arriving with cancel or an accepted item_req are rejected.
  - Credit updates on the edge after the pulse.
- Coins in VEND or CHANGE: always rejected (coin_reject=1 one cycle later). item_req and cancel are ignored in these states.
- VEND:
  - motor held one-hot and the timeout counter increments each cycle.
  - motor_done=1: motor cleared at the next edge, go CHANGE.
  - Counter reaching MOTOR_TIMEOUT without done: motor cleared, fault=1 for 1 cycle, credit restored to the pre-vend value (full refund), go CHANGE.
- CHANGE: alternates pulse and gap cycles.
  - Pulse cycle: if credit>=25, eject_quarter=1 and credit -= 25. Else if credit>=10, eject_dime and -10. Else if credit>=5, eject_nickel and -5.
  - Gap cycle: all eject outputs 0.
  - When credit==0 at a pulse decision point, go IDLE (busy low next cycle) with no pulse. CHANGE entered with credit 0 returns to IDLE in 1 cycle.
- Latency:
  - Coin to credit update: 1 cycle.
  - item_req to motor high: 1 cycle.
  - motor_done to first eject pulse: 2 cycles.
- Arithmetic is unsigned, 7-bit. Credit never wraps: prices and coins are multiples of 5, and the MAX_CREDIT check happens before the add.

Test Plan:
1. Reset, quarter then dime (credit 35), item_req sel=2 -> motor=0100 next cycle, credit 0. motor_done after 3 cycles -> motor=0000, no eject pulses, busy low.
2. Three quarters (75), item_req sel=0 (15), motor_done -> ejects quarter, gap, quarter, gap, dime. Credit 60->35->10->0, then IDLE.
3. Credit 90, quarter -> coin_reject 1 cycle, credit stays 90. Nickel -> credit 95.
4. Credit 10, item_req sel=3 -> insufficient 1 cycle, motor stays 0. Then nickel+dime same cycle -> dime accepted (20), coin_reject=1.
5. Credit 40, cancel -> quarter, dime, nickel pulses with gaps, credit 0. A coin during CHANGE -> coin_reject.
6. Credit 50, item_req sel=1, motor_done never asserted -> fault after MOTOR_TIMEOUT cycles, refund 50 as two quarters. Assert reset mid-refund -> all outputs 0, credit 0 immediately.
